// File: rtl/sf_camera_pkg.sv
// sf_camera_pkg: state encodings and widths shared by the sf_camera power sequencer
package sf_camera_pkg;
  localparam int SEQ_STATE_W = 3;
  localparam int LOSS_CNT_W = 8;
  localparam logic [SEQ_STATE_W-1:0] ST_IDLE        = 3'd0;
  localparam logic [SEQ_STATE_W-1:0] ST_DCM_RESET   = 3'd1;
  localparam logic [SEQ_STATE_W-1:0] ST_WAIT_LOCK   = 3'd2;
  localparam logic [SEQ_STATE_W-1:0] ST_LOCK_STABLE = 3'd3;
  localparam logic [SEQ_STATE_W-1:0] ST_CAM_RESET   = 3'd4;
  localparam logic [SEQ_STATE_W-1:0] ST_CAM_STARTUP = 3'd5;
  localparam logic [SEQ_STATE_W-1:0] ST_READY       = 3'd6;
  localparam logic [SEQ_STATE_W-1:0] ST_FAULT       = 3'd7;
endpackage

// File: rtl/sf_camera_sync.sv
// sf_camera_sync: generic 2-flop synchronizer, async reset to 0
module sf_camera_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/sf_camera_power_seq.sv
// sf_camera_power_seq: clock-generator and sensor power-up/recovery sequencer
module sf_camera_power_seq
  import sf_camera_pkg::*;
#(
  parameter int CNT_WIDTH           = 20,
  parameter int DCM_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CAM_RST_CYCLES      = 50000,
  parameter int STARTUP_CYCLES      = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear_fault,
  input  logic                   locked,
  output logic                   dcm_rst,
  output logic                   cam_pwdn,
  output logic                   cam_rst_n,
  output logic                   ready,
  output logic                   fault,
  output logic [SEQ_STATE_W-1:0] state,
  output logic [LOSS_CNT_W-1:0]  lock_loss_count
);
  logic lk_s, done, loss;
  logic [SEQ_STATE_W-1:0] nxt;
  logic [CNT_WIDTH-1:0] cnt, load;
  logic dcm_rst_d, cam_pwdn_d, cam_rst_n_d;
  sf_camera_sync #(.W(1)) u_lock_sync (.clk(clk), .rst(rst), .d(locked), .q(lk_s));
  assign done = cnt == '0;
  assign loss = enable && !lk_s &&
                (state == ST_CAM_RESET || state == ST_CAM_STARTUP || state == ST_READY);
  always_comb begin
    nxt = state;
    if (state == ST_FAULT) nxt = clear_fault ? ST_IDLE : ST_FAULT;
    else if (!enable) nxt = ST_IDLE;
    else if (loss) nxt = ST_DCM_RESET;
    else
      case (state)
        ST_IDLE:        nxt = ST_DCM_RESET;
        ST_DCM_RESET:   nxt = done ? ST_WAIT_LOCK : state;
        ST_WAIT_LOCK:   nxt = lk_s ? ST_LOCK_STABLE : done ? ST_FAULT : state;
        ST_LOCK_STABLE: nxt = !lk_s ? ST_WAIT_LOCK : done ? ST_CAM_RESET : state;
        ST_CAM_RESET:   nxt = done ? ST_CAM_STARTUP : state;
        ST_CAM_STARTUP: nxt = done ? ST_READY : state;
        default:        nxt = state;
      endcase
  end
  // outputs are decoded from the next state so the registered copy lines up with state
  always_comb begin
    load = nxt == ST_DCM_RESET   ? CNT_WIDTH'(DCM_RST_CYCLES - 1) :
           nxt == ST_WAIT_LOCK   ? CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1) :
           nxt == ST_LOCK_STABLE ? CNT_WIDTH'(LOCK_STABLE_CYCLES - 1) :
           nxt == ST_CAM_RESET   ? CNT_WIDTH'(CAM_RST_CYCLES - 1) :
           nxt == ST_CAM_STARTUP ? CNT_WIDTH'(STARTUP_CYCLES - 1) : '0;
    dcm_rst_d   = nxt == ST_IDLE || nxt == ST_DCM_RESET || nxt == ST_FAULT;
    cam_pwdn_d  = nxt == ST_IDLE || nxt == ST_DCM_RESET || nxt == ST_WAIT_LOCK ||
                  nxt == ST_LOCK_STABLE || nxt == ST_FAULT;
    cam_rst_n_d = nxt == ST_CAM_STARTUP || nxt == ST_READY;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      dcm_rst         <= 1'b1;
      cam_pwdn        <= 1'b1;
      cam_rst_n       <= 1'b0;
      ready           <= 1'b0;
      fault           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state           <= nxt;
      cnt             <= nxt != state ? load : done ? cnt : cnt - CNT_WIDTH'(1);
      dcm_rst         <= dcm_rst_d;
      cam_pwdn        <= cam_pwdn_d;
      cam_rst_n       <= cam_rst_n_d;
      ready           <= nxt == ST_READY;
      fault           <= nxt == ST_FAULT;
      lock_loss_count <= lock_loss_count + LOSS_CNT_W'(loss && lock_loss_count != '1);
    end
endmodule
